// File: rtl/ins_decoder.sv
// ins_decoder: pulls one instruction at a time from the fetch FIFO, decodes
// the 2-bit type and dispatches it to the load engine, the save engine or the
// PE array controller. Config instructions update the layer configuration
// registers only after every in-flight load, save and compute has completed.
// Errors are reported through a sticky flag that keeps the first cause.
module ins_decoder #(
  parameter int INST_W = 64,
  parameter int OUT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,

  // instruction stream from the fetch FIFO
  input  logic              ins_valid,
  input  logic [INST_W-1:0] ins,
  output logic              ins_ready,

  // layer configuration
  output logic              cfg_valid,
  output logic [3:0]        layer_type,
  output logic [3:0]        in_seg,
  output logic [3:0]        out_seg,
  output logic [7:0]        in_img_w,
  output logic [7:0]        out_img_w,

  // DDR load engine
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [3:0]        rd_op,
  output logic [5:0]        rd_buf_id,
  output logic [7:0]        rd_size,
  output logic [31:0]       rd_addr,

  // DDR save engine
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [3:0]        wr_op,
  output logic [5:0]        wr_buf_id,
  output logic [7:0]        wr_size,
  output logic [31:0]       wr_addr,

  // PE array controller
  output logic              pe_valid,
  input  logic              pe_ready,
  output logic [INST_W-1:0] pe_ins,

  // completion pulses
  input  logic              rd_done,
  input  logic              wr_done,
  input  logic              pe_done,

  // status and errors
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    T_LOAD = 2'b00,
    T_SAVE = 2'b01,
    T_COMP = 2'b10,
    T_CFG  = 2'b11
  } ins_type_t;

  localparam logic [1:0] ERR_LOAD_OP = 2'b01;
  localparam logic [1:0] ERR_SAVE_OP = 2'b10;
  localparam logic [1:0] ERR_NO_CFG  = 2'b11;

  localparam logic [OUT_W-1:0] CNT_MAX = '1;
  localparam logic [OUT_W-1:0] CNT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  // opcodes the load engine implements
  function automatic logic load_op_ok(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1000: load_op_ok = 1'b1;
      default:                   load_op_ok = 1'b0;
    endcase
  endfunction

  // opcodes the save engine implements
  function automatic logic save_op_ok(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0010, 4'b0011,
      4'b0100, 4'b0101: save_op_ok = 1'b1;
      default:          save_op_ok = 1'b0;
    endcase
  endfunction

  // Outstanding-operation update. A done pulse with nothing outstanding is
  // ignored so a stray pulse cannot wrap the counter to its maximum.
  function automatic logic [OUT_W-1:0] cnt_next(input logic [OUT_W-1:0] c,
                                                input logic             inc,
                                                input logic             done);
    logic dec;
    dec = done && (c != '0);
    if (inc && !dec)
      cnt_next = c + CNT_ONE;
    else if (dec && !inc)
      cnt_next = c - CNT_ONE;
    else
      cnt_next = c;
  endfunction

  state_t     state, state_nxt;
  ins_type_t  in_type;
  ins_type_t  issue_type;
  logic [3:0] in_op;

  logic [OUT_W-1:0] rd_cnt, wr_cnt, pe_cnt;
  logic             cnt_zero;

  logic accept;
  logic take_issue;
  logic take_cfg;
  logic apply_cfg;
  logic new_err;
  logic [1:0] new_code;
  logic rd_hs, wr_hs, pe_hs;

  // config word waiting for the drain to finish
  logic [3:0] pend_layer_type;
  logic [3:0] pend_in_seg;
  logic [3:0] pend_out_seg;
  logic [7:0] pend_in_img_w;
  logic [7:0] pend_out_img_w;

  assign in_type  = ins_type_t'(ins[INST_W-1 -: 2]);
  assign in_op    = ins[61:58];
  assign accept   = ins_valid && ins_ready;
  assign cnt_zero = (rd_cnt == '0) && (wr_cnt == '0) && (pe_cnt == '0);

  // Handshake signals are pure functions of state and counters, so an
  // asynchronous reset drops any in-flight valid immediately.
  assign ins_ready = (state == S_IDLE);
  assign rd_valid  = (state == S_ISSUE) && (issue_type == T_LOAD) && (rd_cnt != CNT_MAX);
  assign wr_valid  = (state == S_ISSUE) && (issue_type == T_SAVE) && (wr_cnt != CNT_MAX);
  assign pe_valid  = (state == S_ISSUE) && (issue_type == T_COMP) && (pe_cnt != CNT_MAX);

  assign rd_hs = rd_valid && rd_ready;
  assign wr_hs = wr_valid && wr_ready;
  assign pe_hs = pe_valid && pe_ready;

  assign busy = !cnt_zero || (state != S_IDLE);

  // Next-state decode: classify the accepted instruction and pick the state.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    take_issue = 1'b0;
    take_cfg   = 1'b0;
    apply_cfg  = 1'b0;
    new_err    = 1'b0;
    new_code   = 2'b00;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_type == T_CFG) begin
            take_cfg  = 1'b1;
            state_nxt = S_DRAIN;
          end else if (!cfg_valid) begin
            new_err  = 1'b1;
            new_code = ERR_NO_CFG;
          end else if ((in_type == T_LOAD) && !load_op_ok(in_op)) begin
            new_err  = 1'b1;
            new_code = ERR_LOAD_OP;
          end else if ((in_type == T_SAVE) && !save_op_ok(in_op)) begin
            new_err  = 1'b1;
            new_code = ERR_SAVE_OP;
          end else begin
            take_issue = 1'b1;
            state_nxt  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (rd_hs || wr_hs || pe_hs)
          state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (cnt_zero) begin
          apply_cfg = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Dispatch field registers: loaded on acceptance and held through ISSUE so
  // they stay stable for as long as the matching valid is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_type <= T_LOAD;
      rd_op      <= '0;
      rd_buf_id  <= '0;
      rd_size    <= '0;
      rd_addr    <= '0;
      wr_op      <= '0;
      wr_buf_id  <= '0;
      wr_size    <= '0;
      wr_addr    <= '0;
      pe_ins     <= '0;
    end else if (take_issue) begin
      issue_type <= in_type;
      case (in_type)
        T_LOAD: begin
          rd_op     <= ins[61:58];
          rd_buf_id <= ins[57:52];
          rd_size   <= ins[39:32];
          rd_addr   <= ins[31:0];
        end
        T_SAVE: begin
          wr_op     <= ins[61:58];
          wr_buf_id <= ins[57:52];
          wr_size   <= ins[39:32];
          wr_addr   <= ins[31:0];
        end
        default: pe_ins <= ins;
      endcase
    end
  end

  // Config staging and apply: capture on acceptance, publish once drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_layer_type <= '0;
      pend_in_seg     <= '0;
      pend_out_seg    <= '0;
      pend_in_img_w   <= '0;
      pend_out_img_w  <= '0;
      cfg_valid       <= 1'b0;
      layer_type      <= '0;
      in_seg          <= '0;
      out_seg         <= '0;
      in_img_w        <= '0;
      out_img_w       <= '0;
    end else begin
      if (take_cfg) begin
        pend_layer_type <= ins[61:58];
        pend_in_seg     <= ins[55:52];
        pend_out_seg    <= ins[51:48];
        pend_in_img_w   <= ins[47:40];
        pend_out_img_w  <= ins[39:32];
      end
      if (apply_cfg) begin
        cfg_valid  <= 1'b1;
        layer_type <= pend_layer_type;
        in_seg     <= pend_in_seg;
        out_seg    <= pend_out_seg;
        in_img_w   <= pend_in_img_w;
        out_img_w  <= pend_out_img_w;
      end
    end
  end

  // Outstanding-operation counters, one per consumer channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      pe_cnt <= '0;
    end else begin
      rd_cnt <= cnt_next(rd_cnt, rd_hs, rd_done);
      wr_cnt <= cnt_next(wr_cnt, wr_hs, wr_done);
      pe_cnt <= cnt_next(pe_cnt, pe_hs, pe_done);
    end
  end

  // Sticky error: keeps the first cause until cleared; a fresh error in the
  // clearing cycle replaces the old cause instead of being lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (new_err) begin
      err <= 1'b1;
      if (!err || err_clr)
        err_code <= new_code;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_code <= 2'b00;
    end
  end

endmodule

// File: tb/tb_ins_decoder.sv
// tb_ins_decoder: directed, table-driven bench for ins_decoder with
// hand-written sequences for the drain barrier, counter saturation, error
// priority and asynchronous reset.
module tb_ins_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid;
  logic [63:0] ins;
  logic        ins_ready;
  logic        cfg_valid;
  logic [3:0]  layer_type, in_seg, out_seg;
  logic [7:0]  in_img_w, out_img_w;
  logic        rd_valid, rd_ready;
  logic [3:0]  rd_op;
  logic [5:0]  rd_buf_id;
  logic [7:0]  rd_size;
  logic [31:0] rd_addr;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_op;
  logic [5:0]  wr_buf_id;
  logic [7:0]  wr_size;
  logic [31:0] wr_addr;
  logic        pe_valid, pe_ready;
  logic [63:0] pe_ins;
  logic        rd_done, wr_done, pe_done;
  logic        busy, err, err_clr;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ins_decoder #(.INST_W(64), .OUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins(ins), .ins_ready(ins_ready),
    .cfg_valid(cfg_valid), .layer_type(layer_type), .in_seg(in_seg),
    .out_seg(out_seg), .in_img_w(in_img_w), .out_img_w(out_img_w),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_op(rd_op),
    .rd_buf_id(rd_buf_id), .rd_size(rd_size), .rd_addr(rd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_op(wr_op),
    .wr_buf_id(wr_buf_id), .wr_size(wr_size), .wr_addr(wr_addr),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_ins(pe_ins),
    .rd_done(rd_done), .wr_done(wr_done), .pe_done(pe_done),
    .busy(busy), .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  typedef struct {
    logic [63:0] w;      // instruction word
    logic [1:0]  kind;   // 0 load, 1 save, 2 compute
    logic        ok;     // expected to dispatch
    logic [1:0]  code;   // expected err_code when rejected
    logic [3:0]  op;
    logic [5:0]  bid;
    logic [7:0]  size;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // advance one clock; drive and sample 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w);
    ins       = w;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
  endtask

  function automatic logic [63:0] mk(input logic [1:0] t, input logic [3:0] op,
                                     input logic [5:0] bid, input logic [7:0] size,
                                     input logic [31:0] addr);
    mk = {t, op, bid, 12'h000, size, addr};
  endfunction

  // config fields: [61:58] layer_type, [55:52] in_seg, [51:48] out_seg,
  // [47:40] in_img_w, [39:32] out_img_w
  localparam logic [63:0] CFG_A = 64'hC4A5_2010_0000_0000; // lt 1, in A, out 5, 20, 10
  localparam logic [63:0] CFG_B = 64'hE83C_4080_0000_0000; // lt A, in 3, out C, 40, 80
  localparam logic [63:0] COMP  = 64'h8123_4567_89AB_CDEF;

  initial begin
    rst = 1'b0; ins_valid = 1'b0; ins = '0;
    rd_ready = 1'b1; wr_ready = 1'b1; pe_ready = 1'b1;
    rd_done = 1'b0; wr_done = 1'b0; pe_done = 1'b0; err_clr = 1'b0;

    vecs[0] = '{mk(2'b00, 4'b0100, 6'd5,  8'd16,  32'h1000_0000), 2'd0, 1'b1, 2'b00, 4'b0100, 6'd5,  8'd16,  32'h1000_0000};
    vecs[1] = '{mk(2'b00, 4'b1000, 6'd63, 8'd255, 32'hFFFF_FFFF), 2'd0, 1'b1, 2'b00, 4'b1000, 6'd63, 8'd255, 32'hFFFF_FFFF};
    vecs[2] = '{mk(2'b00, 4'b0001, 6'd1,  8'd4,   32'h0000_0040), 2'd0, 1'b0, 2'b01, 4'b0000, 6'd0,  8'd0,   32'h0};
    vecs[3] = '{mk(2'b01, 4'b0011, 6'd2,  8'd1,   32'h0000_ABCD), 2'd1, 1'b1, 2'b00, 4'b0011, 6'd2,  8'd1,   32'h0000_ABCD};
    vecs[4] = '{mk(2'b01, 4'b0110, 6'd9,  8'd8,   32'h0000_0100), 2'd1, 1'b0, 2'b10, 4'b0000, 6'd0,  8'd0,   32'h0};
    vecs[5] = '{mk(2'b01, 4'b0000, 6'd0,  8'd0,   32'h0000_0000), 2'd1, 1'b1, 2'b00, 4'b0000, 6'd0,  8'd0,   32'h0};
    vecs[6] = '{COMP,                                             2'd2, 1'b1, 2'b00, 4'b0000, 6'd0,  8'd0,   32'h0};
    vecs[7] = '{mk(2'b00, 4'b0011, 6'd7,  8'd2,   32'h0000_0200), 2'd0, 1'b0, 2'b01, 4'b0000, 6'd0,  8'd0,   32'h0};

    // reset state
    #12;
    check("rst_ins_ready", ins_ready, 1'b1);
    check("rst_valids", {rd_valid, wr_valid, pe_valid, cfg_valid}, 4'b0000);
    check("rst_err", {err, err_code}, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_fields", {rd_op, wr_op, layer_type, rd_addr}, 44'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // stray done pulse with nothing outstanding is ignored
    pe_done = 1'b1; tick(); pe_done = 1'b0;
    check("stray_done_busy", busy, 1'b0);

    // load before any config is dropped with code 11
    send(mk(2'b00, 4'b0100, 6'd5, 8'd16, 32'h1000_0000));
    check("nocfg_err", {err, err_code}, 3'b111);
    check("nocfg_rd_valid", rd_valid, 1'b0);
    check("nocfg_ready", ins_ready, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("nocfg_clr", {err, err_code}, 3'b000);

    // config with counters idle: applied two edges after acceptance
    send(CFG_A);
    check("cfg_drain_ready", ins_ready, 1'b0);
    check("cfg_not_yet", cfg_valid, 1'b0);
    tick();
    check("cfg_valid", cfg_valid, 1'b1);
    check("cfg_fields", {layer_type, in_seg, out_seg, in_img_w, out_img_w}, 28'h1A5_2010);
    check("cfg_ready", ins_ready, 1'b1);

    // table of dispatch vectors
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].w);
      if (vecs[i].ok) begin
        check($sformatf("v%0d_valids", i), {rd_valid, wr_valid, pe_valid},
              {vecs[i].kind == 2'd0, vecs[i].kind == 2'd1, vecs[i].kind == 2'd2});
        check($sformatf("v%0d_ready", i), ins_ready, 1'b0);
        if (vecs[i].kind == 2'd0)
          check($sformatf("v%0d_rd_fields", i), {rd_op, rd_buf_id, rd_size, rd_addr},
                {vecs[i].op, vecs[i].bid, vecs[i].size, vecs[i].addr});
        else if (vecs[i].kind == 2'd1)
          check($sformatf("v%0d_wr_fields", i), {wr_op, wr_buf_id, wr_size, wr_addr},
                {vecs[i].op, vecs[i].bid, vecs[i].size, vecs[i].addr});
        else
          check($sformatf("v%0d_pe_ins", i), pe_ins, vecs[i].w);
        tick();
        check($sformatf("v%0d_deassert", i), {rd_valid, wr_valid, pe_valid, ins_ready}, 4'b0001);
        check($sformatf("v%0d_outstanding", i), busy, 1'b1);
        rd_done = (vecs[i].kind == 2'd0);
        wr_done = (vecs[i].kind == 2'd1);
        pe_done = (vecs[i].kind == 2'd2);
        tick();
        rd_done = 1'b0; wr_done = 1'b0; pe_done = 1'b0;
        check($sformatf("v%0d_drained", i), busy, 1'b0);
      end else begin
        check($sformatf("v%0d_err", i), {err, err_code}, {1'b1, vecs[i].code});
        check($sformatf("v%0d_no_valid", i), {rd_valid, wr_valid, pe_valid, busy}, 4'b0000);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check($sformatf("v%0d_clr", i), {err, err_code}, 3'b000);
      end
    end

    // first error is kept; a new error in the clearing cycle wins
    send(mk(2'b01, 4'b0001, 6'd0, 8'd0, 32'h0));
    check("sv_bad_err", {err, err_code, wr_valid}, 4'b1100);
    send(mk(2'b00, 4'b1111, 6'd0, 8'd0, 32'h0));
    check("first_err_kept", {err, err_code}, 3'b110);
    err_clr = 1'b1;
    send(mk(2'b00, 4'b1111, 6'd0, 8'd0, 32'h0));
    err_clr = 1'b0;
    check("clr_vs_new_err", {err, err_code}, 3'b101);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_cleared", {err, err_code}, 3'b000);

    // counter saturation: 15 loads outstanding holds the 16th
    for (int i = 0; i < 15; i++) begin
      send(mk(2'b00, 4'b0000, 6'(i), 8'd1, 32'(i)));
      tick();
    end
    check("sat_15_ready", ins_ready, 1'b1);
    send(mk(2'b00, 4'b0010, 6'd16, 8'd2, 32'h0000_1600));
    check("sat_hold0", rd_valid, 1'b0);
    tick();
    check("sat_hold1", {rd_valid, ins_ready}, 2'b00);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    check("sat_release", rd_valid, 1'b1);
    check("sat_fields", {rd_op, rd_buf_id, rd_addr}, {4'b0010, 6'd16, 32'h0000_1600});
    tick();
    check("sat_issued", {rd_valid, ins_ready}, 2'b01);
    for (int i = 0; i < 15; i++) begin
      rd_done = 1'b1; tick(); rd_done = 1'b0;
    end
    check("sat_drained", busy, 1'b0);

    // config barrier with two computes in flight
    send(COMP); tick();
    send(COMP); tick();
    send(CFG_B);
    check("bar_ready", ins_ready, 1'b0);
    tick(); tick();
    check("bar_hold", {layer_type, in_seg, out_seg, in_img_w, out_img_w}, 28'h1A5_2010);
    pe_done = 1'b1; tick(); pe_done = 1'b0;
    check("bar_hold1", {ins_ready, layer_type}, {1'b0, 4'h1});
    pe_done = 1'b1; tick(); pe_done = 1'b0;
    check("bar_hold2", {ins_ready, layer_type}, {1'b0, 4'h1});
    tick();
    check("bar_applied", {layer_type, in_seg, out_seg, in_img_w, out_img_w}, 28'hA3C_4080);
    check("bar_ready_back", {ins_ready, busy}, 2'b10);

    // asynchronous reset while a load waits on rd_ready
    rd_ready = 1'b0;
    send(mk(2'b00, 4'b0101, 6'd3, 8'd8, 32'h0000_0300));
    check("rst_pre_valid", rd_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_valid", {rd_valid, cfg_valid, ins_ready}, 3'b001);
    check("rst_mid_fields", {rd_op, layer_type, busy}, 9'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_after", {rd_valid, cfg_valid, ins_ready, err}, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
